// File: rtl/sram_responder_if.sv
`default_nettype none
// ============================================================================
// sram_responder_if : asynchronous-SRAM pin bundle (controller <-> responder)
// Revision: 1.0
// ============================================================================
interface sram_responder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  iCE_n;
    logic                  iWE_n;
    logic                  iOE_n;
    logic [ADDR_WIDTH-1:0] iAddress;
    logic [DATA_WIDTH-1:0] iDataIn;
    logic [DATA_WIDTH-1:0] oDataOut;
    logic                  oDataValid;
    logic                  oWriteViolation;
    logic [7:0]            oViolationCount;

    modport master (
        output iCE_n, iWE_n, iOE_n, iAddress, iDataIn,
        input  oDataOut, oDataValid, oWriteViolation, oViolationCount
    );

    modport slave (
        input  iCE_n, iWE_n, iOE_n, iAddress, iDataIn,
        output oDataOut, oDataValid, oWriteViolation, oViolationCount
    );
endinterface
`default_nettype wire

// File: rtl/sram_responder.sv
`default_nettype none
// ============================================================================
// sram_responder : async-SRAM emulator with read latency, write-pulse checking
// Revision: 1.0
// ============================================================================
module sram_responder #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int MIN_WE_CYCLES = 1
) (
    input  wire logic        Clock,
    input  wire logic        Reset,
    sram_responder_if.slave  bus
);
    localparam int         c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0] c_READ_LAT = 4'(READ_LATENCY);
    localparam logic [3:0] c_MIN_WE   = 4'(MIN_WE_CYCLES);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        READ_WAIT   = 2'd1,
        READ_DRIVE  = 2'd2,
        WRITE_PULSE = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [3:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic                  r_viol;
    logic [7:0]            r_vcnt;
    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

    logic w_wr;
    logic w_rd;
    logic w_same;
    logic w_commit;
    logic w_violation;

    // A cycle with both WE and OE low counts as a write, never a read.
    assign w_wr        = !bus.iCE_n && !bus.iWE_n;
    assign w_rd        = !bus.iCE_n && !bus.iOE_n && bus.iWE_n;
    assign w_same      = (bus.iAddress == r_addr);
    assign w_commit    = (r_state == WRITE_PULSE) && !w_wr && (r_cnt >= c_MIN_WE);
    assign w_violation = (r_state == WRITE_PULSE) &&
                         ((w_wr && !w_same) || (!w_wr && (r_cnt < c_MIN_WE)));

    // Storage is deliberately outside the reset domain so contents survive Reset.
    always_ff @(posedge Clock) begin
        if (w_commit) begin
            r_mem[r_addr] <= r_data;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_cnt   <= 4'd0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_viol  <= 1'b0;
            r_vcnt  <= 8'd0;
        end else begin
            if (w_violation) begin
                r_viol <= 1'b1;
                if (r_vcnt != 8'hFF) begin
                    r_vcnt <= r_vcnt + 8'd1;
                end
            end

            // Any non-write state treats a write strobe as a fresh write start.
            if (w_wr && (r_state != WRITE_PULSE)) begin
                r_state <= WRITE_PULSE;
                r_addr  <= bus.iAddress;
                r_data  <= bus.iDataIn;
                r_cnt   <= 4'd1;
                r_valid <= 1'b0;
                r_dout  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rd) begin
                            r_state <= READ_WAIT;
                            r_addr  <= bus.iAddress;
                            r_cnt   <= 4'd1;
                        end
                    end
                    READ_WAIT: begin
                        if (w_rd && w_same) begin
                            // r_cnt equals the number of edges elapsed since the first RD sample.
                            if (r_cnt == c_READ_LAT) begin
                                r_dout  <= r_mem[r_addr];
                                r_valid <= 1'b1;
                                r_state <= READ_DRIVE;
                            end else begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else if (w_rd) begin
                            r_addr <= bus.iAddress;
                            r_cnt  <= 4'd1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    READ_DRIVE: begin
                        if (!(w_rd && w_same)) begin
                            r_valid <= 1'b0;
                            r_dout  <= '0;
                            if (w_rd) begin
                                r_state <= READ_WAIT;
                                r_addr  <= bus.iAddress;
                                r_cnt   <= 4'd1;
                            end else begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    WRITE_PULSE: begin
                        if (w_wr && w_same) begin
                            r_data <= bus.iDataIn;
                            if (r_cnt != 4'hF) begin
                                r_cnt <= r_cnt + 4'd1;
                            end
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.oDataOut        = r_dout;
    assign bus.oDataValid      = r_valid;
    assign bus.oWriteViolation = r_viol;
    assign bus.oViolationCount = r_vcnt;
endmodule
`default_nettype wire

// File: doc/sram_responder.md
Name: sram_responder

Overview:
On-chip responder for the asynchronous-SRAM pin interface driven by the team's SRAM controller. It sits on the far side of the address, data and strobe lines, emulating a DEPTH x DATA_WIDTH asynchronous SRAM with a configurable read access time and a minimum write pulse width. It flags protocol violations so the controller's timing can be checked both in simulation and in hardware loopback.

Parameters:
DATA_WIDTH, 16, word width
ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH words (derived)
READ_LATENCY, 2, cycles from the sampled read request to valid data; legal values 1..15
MIN_WE_CYCLES, 1, minimum cycles iWE_n must be held low for a write to commit; legal values 1..15

Ports:
Clock  in  1  system clock
Reset  in  1  reset
iCE_n  in  1  chip enable, active-low
iWE_n  in  1  write enable, active-low
iOE_n  in  1  output enable, active-low
iAddress  in  ADDR_WIDTH  address from controller
iDataIn  in  DATA_WIDTH  write data from controller
oDataOut  out  DATA_WIDTH  read data to controller
oDataValid  out  1  oDataOut holds valid read data
oWriteViolation  out  1  sticky: a write was aborted or too short
oViolationCount  out  8  saturating count of violations

Behaviour:
- Reset: asynchronous, active-high. Clock: Clock, rising edge. All logic is synchronous to Clock except reset.
- On reset: state=IDLE; oDataOut=0, oDataValid=0, oWriteViolation=0, oViolationCount=0; captured address, data and counter cleared.
- Memory array is not reset. Contents survive Reset. Reading an unwritten location returns X in simulation.
- Definitions: WR = !iCE_n & !iWE_n. RD = !iCE_n & !iOE_n & iWE_n. If WE and OE are both low, the cycle is a write.
- States: IDLE, READ_WAIT, READ_DRIVE, WRITE_PULSE. The counter is 4 bits.
- IDLE:
  - If WR: go to WRITE_PULSE; capture addr=iAddress, data=iDataIn; cnt=1.
  - Else if RD: go to READ_WAIT; capture addr; cnt=1.
  - Otherwise stay in IDLE.
- WRITE_PULSE:
  - While WR and iAddress==addr: data<=iDataIn (last value before WE rises is written); cnt saturates at 15.
  - WR and iAddress!=addr: abort with no write; raise violation; go to IDLE.
  - !WR: if cnt>=MIN_WE_CYCLES, mem[addr]<=data and go to IDLE. Otherwise raise violation, no write, go to IDLE.
- READ_WAIT:
  - RD and iAddress==addr: cnt++. When cnt==READ_LATENCY, load oDataOut<=mem[addr], set oDataValid=1, go to READ_DRIVE.
  - The READ_LATENCY==1 case must also work: oDataValid is high on the edge after the IDLE sampling edge. In general, with RD first sampled at edge k, oDataValid rises at edge k+READ_LATENCY.
  - RD with a new address: addr<=iAddress, cnt=1, stay in READ_WAIT (access restarts).
  - WR: go to WRITE_PULSE as from IDLE.
  - Otherwise: go to IDLE.
- READ_DRIVE:
  - RD with same address: hold oDataOut and oDataValid=1.
  - Address change: oDataValid=0 next edge; go to READ_WAIT with the new address, cnt=1.
  - WR: oDataValid=0; go to WRITE_PULSE as from IDLE.
  - Otherwise: oDataValid=0, oDataOut=0, go to IDLE.
- oDataOut is 0 whenever oDataValid is 0. No tristate inside the block.
- Violation event:
  - oWriteViolation<=1 and stays set until Reset.
  - oViolationCount increments by 1 and saturates at 255 (no wrap).
- Reset mid-write: the pending write is discarded and memory is untouched.
- Reset mid-read: oDataValid drops immediately (asynchronously).
- Write-then-read of the same address: the read observes the new data, because the commit edge precedes READ_WAIT entry.

Test Plan:
- Write then read: WR addr 0x12, data 0xBEEF for 2 cycles, WE high; then RD at 0x12 -> oDataValid rises exactly 2 edges after the RD sample with oDataOut=0xBEEF; no violation.
- Short write: MIN_WE_CYCLES=3, WE low 2 cycles at addr 0x05, data 0x1234 -> mem[0x05] unchanged; oWriteViolation=1; oViolationCount=1.
- Address change during write: WE low at 0x20, iAddress becomes 0x21 next cycle -> neither location written; count increments.
- Read address change: RD at 0x01 (0xAAAA); after valid, switch to 0x02 (0x5555) -> oDataValid low for 2 cycles, then valid with 0x5555.
- Reset mid-write: assert Reset during WRITE_PULSE at 0x30 -> mem[0x30] keeps its old value; all outputs 0; state IDLE; a subsequent normal write succeeds.
- Saturation: 260 short writes -> oViolationCount=255, oWriteViolation=1.
